demorgan_sweep_ctrl: RTL and testbench

DEMORGAN_SWEEP_CTRL -- requirements
Module: demorgan_sweep_ctrl

---
 rtl/demorgan_sweep_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_demorgan_sweep_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/demorgan_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// demorgan_sweep_ctrl
//
// Walks the DeMorgan gate block through its full two-input truth table
// ({A,B} = 00, 01, 10, 11). Each vector is held for SETTLE cycles before
// the gate outputs are compared against the ideal response. Every mismatch
// is accumulated into a per-vector error flag and a per-output sticky mask.
// A single pass/fail verdict is produced when the sweep completes.
//
// Parameters
//   SETTLE     cycles a_out/b_out are held before obs is sampled (1..15)
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   reset      asynchronous, active-high; clears all state immediately
//   start      request a sweep; only honoured while idle
//   abort      abandon a sweep in progress (ignored once the sweep is done)
//   a_out      stimulus A to the gate block (0 while idle/done)
//   b_out      stimulus B to the gate block (0 while idle/done)
//   obs[7:0]   gate outputs: [0]nA [1]nB [2]nAandnB [3]AorB
//                            [4]npAorB [5]nAornB [6]AandB [7]npAandB
//   busy       high whenever a sweep is in progress (any non-idle state)
//   done       one-cycle pulse when a sweep completes normally
//   pass       verdict of the last completed sweep (1 = no mismatches)
//   err_vec    bit i set if vector {A,B}=i produced any mismatch
//   fail_mask  sticky OR of mismatching obs bits, same order as obs
// -----------------------------------------------------------------------------
module demorgan_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       a_out,
  output logic       b_out,
  input  logic [7:0] obs,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_vec,
  output logic [7:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Last value of the settle counter before the compare cycle.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] vec;
  logic [1:0] vec_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [3:0] err_nxt;
  logic [7:0] fmask_nxt;
  logic       pass_nxt;

  logic [7:0] diff;
  logic       mismatch;
  logic       driving;

  // Ideal gate-block response for inputs a, b, in obs bit order.
  function automatic logic [7:0] expected_obs(input logic a, input logic b);
    logic [7:0] e;
    e[0] = ~a;
    e[1] = ~b;
    e[2] = ~a & ~b;
    e[3] = a | b;
    e[4] = ~(a | b);
    e[5] = ~a | ~b;
    e[6] = a & b;
    e[7] = ~(a & b);
    return e;
  endfunction

  // Stimulus is only presented while a vector is being driven or checked.
  assign driving  = (state == DRIVE) || (state == CHECK);
  assign a_out    = driving & vec[1];
  assign b_out    = driving & vec[0];
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  assign diff     = obs ^ expected_obs(vec[1], vec[0]);
  assign mismatch = |diff;

  // Next-state and result-update logic.
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    err_nxt   = err_vec;
    fmask_nxt = fail_mask;
    pass_nxt  = pass;

    case (state)
      IDLE: begin
        // abort has priority over start, so a simultaneous request is dropped
        // and the previous results stay visible.
        if (start && !abort) begin
          state_nxt = DRIVE;
          vec_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
          err_nxt   = 4'd0;
          fmask_nxt = 8'd0;
          pass_nxt  = 1'b0;
        end
      end

      DRIVE: begin
        if (abort) begin
          // Partial err_vec/fail_mask are kept for diagnosis.
          state_nxt = IDLE;
          vec_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
          pass_nxt  = 1'b0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end

      CHECK: begin
        if (abort) begin
          // The compare in an aborted cycle is discarded.
          state_nxt = IDLE;
          vec_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
          pass_nxt  = 1'b0;
        end else begin
          fmask_nxt = fail_mask | diff;
          err_nxt   = err_vec | (4'({3'b000, mismatch}) << vec);
          if (vec == 2'd3) begin
            // Verdict must include the final vector's compare, so it is
            // taken from the updated error vector, not the registered one.
            state_nxt = DONE;
            pass_nxt  = (err_nxt == 4'd0);
          end else begin
            state_nxt = DRIVE;
            vec_nxt   = vec + 2'd1;
            cnt_nxt   = 4'd0;
          end
        end
      end

      DONE: begin
        // abort is deliberately ignored here: the sweep already completed.
        state_nxt = IDLE;
        vec_nxt   = 2'd0;
        cnt_nxt   = 4'd0;
      end

      default: begin
        state_nxt = IDLE;
        vec_nxt   = 2'd0;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vec       <= 2'd0;
      cnt       <= 4'd0;
      err_vec   <= 4'd0;
      fail_mask <= 8'd0;
      pass      <= 1'b0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      cnt       <= cnt_nxt;
      err_vec   <= err_nxt;
      fail_mask <= fmask_nxt;
      pass      <= pass_nxt;
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demorgan_sweep_ctrl
//
// Two controller instances (SETTLE=1 and SETTLE=3) each drive a behavioural
// gate block given as a literal truth table, with an optional stuck-at-0
// fault mask on its outputs. Directed sequences cover full sweeps, faults,
// aborts in each state, start/abort collisions and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_demorgan_sweep_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_s [2];
  logic       abort_s [2];
  logic       a_s     [2];
  logic       b_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [3:0] err_s   [2];
  logic [7:0] fm_s    [2];
  logic [7:0] obs_s   [2];
  logic [7:0] stuck0  [2];

  int checks = 0;
  int errors = 0;

  // Gate block outputs, bits 7..0, worked out by hand for each {A,B}.
  function automatic logic [7:0] gate_tbl(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 8'hB7;
      2'b01:   return 8'hA9;
      2'b10:   return 8'hAA;
      default: return 8'h48;
    endcase
  endfunction

  assign obs_s[0] = gate_tbl(a_s[0], b_s[0]) & ~stuck0[0];
  assign obs_s[1] = gate_tbl(a_s[1], b_s[1]) & ~stuck0[1];

  demorgan_sweep_ctrl #(.SETTLE(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start_s[0]), .abort(abort_s[0]),
    .a_out(a_s[0]), .b_out(b_s[0]), .obs(obs_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .pass(pass_s[0]), .err_vec(err_s[0]), .fail_mask(fm_s[0])
  );

  demorgan_sweep_ctrl #(.SETTLE(3)) u_s3 (
    .clk(clk), .reset(reset), .start(start_s[1]), .abort(abort_s[1]),
    .a_out(a_s[1]), .b_out(b_s[1]), .obs(obs_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .pass(pass_s[1]), .err_vec(err_s[1]), .fail_mask(fm_s[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All outputs of instance i must be zero.
  task automatic check_cleared(input int i, input string tag);
    check({tag, " busy"}, 32'(busy_s[i]), 0);
    check({tag, " done"}, 32'(done_s[i]), 0);
    check({tag, " pass"}, 32'(pass_s[i]), 0);
    check({tag, " err"},  32'(err_s[i]),  0);
    check({tag, " fmask"}, 32'(fm_s[i]),  0);
    check({tag, " ab"},   32'({a_s[i], b_s[i]}), 0);
  endtask

  // Called right after a negedge. Runs one sweep and checks latency, stimulus
  // hold time per vector, verdict and results after return to idle.
  task automatic run_sweep(input int i, input int settle, input string tag,
                           input logic exp_pass, input logic [3:0] exp_err,
                           input logic [7:0] exp_fm, input bit repulse,
                           input bit abort_in_done);
    int hold [4];
    int cycles;
    for (int v = 0; v < 4; v++) hold[v] = 0;
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
    cycles = 0;
    while (!done_s[i] && cycles < 200) begin
      if (busy_s[i]) hold[{a_s[i], b_s[i]}]++;
      @(negedge clk);
      cycles++;
      if (repulse && cycles == 3) start_s[i] = 1'b1;
      if (repulse && cycles == 4) start_s[i] = 1'b0;
    end
    check({tag, " latency"}, 32'(cycles), 32'(4 * (settle + 1)));
    for (int v = 0; v < 4; v++)
      check($sformatf("%s hold[%0d]", tag, v), 32'(hold[v]), 32'(settle + 1));
    check({tag, " done"},  32'(done_s[i]), 1);
    check({tag, " busy@done"}, 32'(busy_s[i]), 1);
    check({tag, " pass"},  32'(pass_s[i]), 32'(exp_pass));
    check({tag, " err"},   32'(err_s[i]),  32'(exp_err));
    check({tag, " fmask"}, 32'(fm_s[i]),   32'(exp_fm));
    if (abort_in_done) abort_s[i] = 1'b1;
    @(negedge clk);
    abort_s[i] = 1'b0;
    check({tag, " done gone"}, 32'(done_s[i]), 0);
    check({tag, " idle"},  32'(busy_s[i]), 0);
    check({tag, " pass held"}, 32'(pass_s[i]), 32'(exp_pass));
    check({tag, " err held"},  32'(err_s[i]),  32'(exp_err));
  endtask

  // Wait (bounded) until instance i is busy presenting vector v.
  task automatic wait_vec(input int i, input logic [1:0] v, input string tag);
    int n = 0;
    while (!(busy_s[i] && {a_s[i], b_s[i]} == v) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " reached vec"}, 32'({busy_s[i], a_s[i], b_s[i]}), 32'({1'b1, v}));
  endtask

  task automatic start_pulse(input int i);
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      stuck0[i]  = 8'h00;
    end
    reset = 1'b1;
    #2;
    check_cleared(0, "reset s1");
    check_cleared(1, "reset s3");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fault-free sweeps, second one with start re-pulsed while busy.
    run_sweep(0, 1, "clean", 1'b1, 4'b0000, 8'h00, 1'b0, 1'b0);
    run_sweep(0, 1, "repulse", 1'b1, 4'b0000, 8'h00, 1'b1, 1'b0);
    run_sweep(1, 3, "settle3", 1'b1, 4'b0000, 8'h00, 1'b0, 1'b0);

    // AorB stuck at 0: vectors 1..3 expect AorB=1.
    stuck0[0] = 8'h08;
    run_sweep(0, 1, "stuckAorB", 1'b0, 4'b1110, 8'h08, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("idle hold err", 32'(err_s[0]), 32'h0E);
    check("idle hold fmask", 32'(fm_s[0]), 32'h08);

    // start and abort together while idle: nothing happens.
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    check("collide busy", 32'(busy_s[0]), 0);
    check("collide err", 32'(err_s[0]), 32'h0E);
    @(negedge clk);
    check("collide busy later", 32'(busy_s[0]), 0);

    // Abort while driving vector 2: only vector 1's error is recorded.
    start_pulse(0);
    wait_vec(0, 2'b10, "abort drive");
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    check("abort drive busy", 32'(busy_s[0]), 0);
    check("abort drive pass", 32'(pass_s[0]), 0);
    check("abort drive err", 32'(err_s[0]), 32'b0010);
    check("abort drive fmask", 32'(fm_s[0]), 32'h08);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("abort drive done c%0d", k), 32'(done_s[0]), 0);
      check($sformatf("abort drive ab c%0d", k), 32'({a_s[0], b_s[0]}), 0);
      @(negedge clk);
    end

    // Abort in the CHECK cycle of vector 1: that compare is discarded.
    start_pulse(0);
    wait_vec(0, 2'b01, "abort check");
    @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    check("abort check busy", 32'(busy_s[0]), 0);
    check("abort check err", 32'(err_s[0]), 32'b0000);
    check("abort check fmask", 32'(fm_s[0]), 32'h00);
    check("abort check done", 32'(done_s[0]), 0);

    // Abort during DONE has no effect on the completed result.
    stuck0[0] = 8'h00;
    run_sweep(0, 1, "abort done", 1'b1, 4'b0000, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a CHECK cycle, with results pending.
    stuck0[0] = 8'h08;
    start_pulse(0);
    wait_vec(0, 2'b10, "reset mid");
    @(negedge clk);
    check("pre reset err", 32'(err_s[0]), 32'b0010);
    #1 reset = 1'b1;
    #1;
    check_cleared(0, "async reset");
    start_s[0] = 1'b1;
    @(negedge clk);
    check("start under reset", 32'(busy_s[0]), 0);
    reset = 1'b0;
    stuck0[0] = 8'h00;
    run_sweep(0, 1, "after reset", 1'b1, 4'b0000, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
